// File: rtl/dut_pkg.sv
// Shared constants, header layout and output-port state for the packet crossbar router.
package dut_pkg;
    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 8;
    localparam int DEST_MSB  = 7;
    localparam int DEST_LSB  = 6;
    localparam int LEN_MSB   = 5;
    localparam int LEN_LSB   = 0;
    localparam int DEST_W    = DEST_MSB - DEST_LSB + 1;
    localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;
    localparam int CNT_W     = LEN_W + 1;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  len;
    } header_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    // Beats in a packet including its header; one extra bit so N=63 still fits.
    function automatic logic [CNT_W-1:0] packet_beats(input header_t hdr);
        return CNT_W'(hdr.len) + CNT_W'(1'b1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr (wrapping).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    localparam int IDX_W = PTR_W + 1;

    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // Visit candidates in priority order ptr, ptr+1, ... and grant the first requester.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr} + IDX_W'(k);
            if (idx_s >= IDX_W'(N)) begin
                idx_s = idx_s - IDX_W'(N);
            end else begin
                idx_s = idx_s;
            end
            for (int i = 0; i < N; i++) begin
                if (!found_s && req[i] && (idx_s == IDX_W'(i))) begin
                    grant[i] = 1'b1;
                    found_s  = 1'b1;
                end else begin
                    grant[i] = grant[i];
                end
            end
        end
    end
endmodule

// File: rtl/dut_router.sv
// Packet crossbar: each output locks to one input for a whole header+payload packet,
// arbitrating round-robin while idle, with a single output register per port.
module dut_router #(
    parameter int NUM_PORTS = dut_pkg::NUM_PORTS,
    parameter int DATA_W    = dut_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ready
);
    import dut_pkg::*;

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_W-1:0]    in_byte_s [NUM_PORTS];
    header_t              in_hdr_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] busy_s;
    logic [NUM_PORTS-1:0] req_s     [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_s     [NUM_PORTS];
    logic [PTR_W-1:0]     gnt_idx_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] slot_s;
    logic [NUM_PORTS-1:0] take_s;

    out_state_e           state_q [NUM_PORTS];
    out_state_e           state_d [NUM_PORTS];
    logic [PTR_W-1:0]     src_q   [NUM_PORTS];
    logic [PTR_W-1:0]     src_d   [NUM_PORTS];
    logic [PTR_W-1:0]     ptr_q   [NUM_PORTS];
    logic [PTR_W-1:0]     ptr_d   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d   [NUM_PORTS];
    logic [DATA_W-1:0]    odata_q [NUM_PORTS];
    logic [DATA_W-1:0]    odata_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] ovalid_q;
    logic [NUM_PORTS-1:0] ovalid_d;

    // Split the input bus and view each byte as a potential header.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_byte_s[i] = in_data[i*DATA_W +: DATA_W];
            in_hdr_s[i]  = header_t'(in_byte_s[i][DEST_MSB:LEN_LSB]);
        end
    end

    // A locked input is mid-packet, so its current byte is payload and must not request.
    always_comb begin
        busy_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                busy_s[i] = busy_s[i] | ((state_q[o] == LOCKED) && (src_q[o] == PTR_W'(i)));
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_s[o][i] = in_valid[i] & ~busy_s[i] & (in_hdr_s[i].dest == DEST_W'(o));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_arb
            rr_arbiter #(
                .N     (NUM_PORTS),
                .PTR_W (PTR_W)
            ) u_arb (
                .req   (req_s[g]),
                .ptr   (ptr_q[g]),
                .grant (gnt_s[g])
            );
        end
    endgenerate

    // Handshake: an output register has room when empty or being drained this cycle.
    always_comb begin
        in_ready = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            slot_s[o]    = ~ovalid_q[o] | out_ready[o];
            take_s[o]    = (state_q[o] == LOCKED) & slot_s[o] & in_valid[src_q[o]];
            gnt_idx_s[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt_s[o][i]) begin
                    gnt_idx_s[o] = PTR_W'(i);
                end else begin
                    gnt_idx_s[o] = gnt_idx_s[o];
                end
                in_ready[i] = in_ready[i] |
                              ((state_q[o] == LOCKED) & (src_q[o] == PTR_W'(i)) & slot_s[o]);
            end
        end
    end

    // Per-output lock FSM, beat counter, round-robin pointer and output register.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o]  = state_q[o];
            src_d[o]    = src_q[o];
            ptr_d[o]    = ptr_q[o];
            cnt_d[o]    = cnt_q[o];
            odata_d[o]  = odata_q[o];
            ovalid_d[o] = ovalid_q[o];
            case (state_q[o])
                IDLE: begin
                    if (|req_s[o]) begin
                        state_d[o] = LOCKED;
                        src_d[o]   = gnt_idx_s[o];
                        cnt_d[o]   = packet_beats(in_hdr_s[gnt_idx_s[o]]);
                        ptr_d[o]   = (gnt_idx_s[o] == PTR_W'(NUM_PORTS - 1)) ?
                                     PTR_W'(0) : gnt_idx_s[o] + PTR_W'(1);
                    end else begin
                        state_d[o] = IDLE;
                    end
                end
                LOCKED: begin
                    if (take_s[o]) begin
                        cnt_d[o]   = cnt_q[o] - CNT_W'(1);
                        state_d[o] = (cnt_q[o] == CNT_W'(1)) ? IDLE : LOCKED;
                    end else begin
                        state_d[o] = LOCKED;
                    end
                end
                default: begin
                    state_d[o] = IDLE;
                end
            endcase
            if (take_s[o]) begin
                odata_d[o]  = in_byte_s[src_q[o]];
                ovalid_d[o] = 1'b1;
            end else if (out_ready[o]) begin
                ovalid_d[o] = 1'b0;
            end else begin
                ovalid_d[o] = ovalid_q[o];
            end
        end
    end

    // State registers; reset discards any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= IDLE;
                src_q[o]   <= '0;
                ptr_q[o]   <= '0;
                cnt_q[o]   <= '0;
                odata_q[o] <= '0;
            end
            ovalid_q <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                src_q[o]   <= src_d[o];
                ptr_q[o]   <= ptr_d[o];
                cnt_q[o]   <= cnt_d[o];
                odata_q[o] <= odata_d[o];
            end
            ovalid_q <= ovalid_d;
        end
    end

    // Pack the output registers onto the output bus.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_data[o*DATA_W +: DATA_W] = odata_q[o];
        end
        out_valid = ovalid_q;
    end
endmodule

// File: tb/tb_dut_router.sv
// Directed self-checking bench for dut_router: per-input byte queues, logged outputs.
module tb_dut_router;
    localparam int NP = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;

    dut_router #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hold_viol = 0;
    logic [7:0]    iq   [NP][$];
    logic [7:0]    oq   [NP][$];
    int            ocyc [NP][$];
    int            fireq[$];
    logic [NP-1:0] fire_s;
    logic [NP-1:0] hold_v;
    logic [7:0]    hold_d [NP];

    task automatic apply_inputs();
        for (int i = 0; i < NP; i++) begin
            if (iq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_data[i*DW +: DW] = iq[i][0];
            end else begin
                in_valid[i] = 1'b0;
                in_data[i*DW +: DW] = 8'h00;
            end
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance inputs after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        fire_s = in_valid & in_ready;
        for (int i = 0; i < NP; i++) if (fire_s[i]) fireq.push_back(i);
        for (int o = 0; o < NP; o++) begin
            if (hold_v[o] && (out_valid[o] !== 1'b1 || out_data[o*DW +: DW] !== hold_d[o]))
                hold_viol++;
            if (out_valid[o] && out_ready[o]) begin
                oq[o].push_back(out_data[o*DW +: DW]);
                ocyc[o].push_back(cyc);
            end
            hold_v[o] = out_valid[o] & ~out_ready[o];
            hold_d[o] = out_data[o*DW +: DW];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) if (fire_s[i]) void'(iq[i].pop_front());
        apply_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NP; i++) begin
            iq[i].delete();
            oq[i].delete();
            ocyc[i].delete();
        end
        fireq.delete();
        hold_v = '0;
        hold_viol = 0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_b [2] = '{8'h41, 8'h5A};
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = '1;
        #1;
        reset = 1'b0;
        in_data = $urandom; in_valid = 4'($urandom_range(0, 15));
        #2;
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
        total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        in_valid = '0; in_data = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        iq[0].push_back(8'h41); iq[0].push_back(8'h5A);
        apply_inputs();
        run(8);
        total++; if (oq[1].size() != 2) begin bad++; $display("FAIL reset_pkt_len got=%0d exp=2", oq[1].size()); end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (k >= oq[1].size() || oq[1][k] !== exp_b[k]) begin
                bad++; $display("FAIL reset_pkt_byte%0d got=%0h exp=%0h", k, (k < oq[1].size()) ? oq[1][k] : 8'hxx, exp_b[k]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] pkt [4] = '{8'hC3, 8'hAA, 8'hBB, 8'hCC};
        int start;
        clear_logs(); out_ready = '1;
        for (int k = 0; k < 4; k++) iq[2].push_back(pkt[k]);
        apply_inputs();
        start = cyc + 1;
        run(10);
        total++; if (oq[3].size() != 4) begin bad++; $display("FAIL single_len got=%0d exp=4", oq[3].size()); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= oq[3].size() || oq[3][k] !== pkt[k] || ocyc[3][k] != start + 2 + k) begin
                bad++; $display("FAIL single_byte%0d got=%0h exp=%0h at cycle offset exp=%0d", k,
                                (k < oq[3].size()) ? oq[3][k] : 8'hxx, pkt[k], 2 + k);
            end
        end
        total++;
        if (oq[0].size() + oq[1].size() + oq[2].size() != 0) begin
            bad++; $display("FAIL single_stray got=%0d exp=0", oq[0].size() + oq[1].size() + oq[2].size());
        end
    endtask

    task automatic test_contention();
        int exp_f [6] = '{0, 1, 3, 0, 1, 3};
        clear_logs(); out_ready = '1;
        for (int r = 0; r < 2; r++) begin
            iq[0].push_back(8'h80); iq[1].push_back(8'h80); iq[3].push_back(8'h80);
        end
        apply_inputs();
        run(25);
        total++; if (fireq.size() != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", fireq.size()); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (k >= fireq.size() || fireq[k] != exp_f[k]) begin
                bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, (k < fireq.size()) ? fireq[k] : -1, exp_f[k]);
            end
        end
        total++; if (oq[2].size() != 6) begin bad++; $display("FAIL rr_out_count got=%0d exp=6", oq[2].size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pkt [5] = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_logs(); out_ready = '1;
        for (int k = 0; k < 5; k++) iq[1].push_back(pkt[k]);
        apply_inputs();
        for (int k = 0; k < 20; k++) begin
            out_ready[0] = pat[k % 4];
            step();
        end
        out_ready = '1;
        run(4);
        total++; if (oq[0].size() != 5) begin bad++; $display("FAIL bp_len got=%0d exp=5", oq[0].size()); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= oq[0].size() || oq[0][k] !== pkt[k]) begin
                bad++; $display("FAIL bp_byte%0d got=%0h exp=%0h", k, (k < oq[0].size()) ? oq[0][k] : 8'hxx, pkt[k]);
            end
        end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    endtask

    task automatic test_concurrency();
        logic [7:0] pa [11];
        logic [7:0] pb [11];
        int start;
        clear_logs(); out_ready = '1;
        pa[0] = 8'hCA; pb[0] = 8'h0A;
        for (int k = 1; k < 11; k++) begin
            pa[k] = 8'(k);
            pb[k] = 8'hA0 + 8'(k);
        end
        for (int k = 0; k < 11; k++) begin
            iq[0].push_back(pa[k]); iq[3].push_back(pb[k]);
        end
        apply_inputs();
        start = cyc + 1;
        run(16);
        total++; if (oq[3].size() != 11) begin bad++; $display("FAIL xbar_len3 got=%0d exp=11", oq[3].size()); end
        total++; if (oq[0].size() != 11) begin bad++; $display("FAIL xbar_len0 got=%0d exp=11", oq[0].size()); end
        for (int k = 0; k < 11; k++) begin
            total++;
            if (k >= oq[3].size() || oq[3][k] !== pa[k] || ocyc[3][k] != start + 2 + k) begin
                bad++; $display("FAIL xbar_out3_byte%0d got=%0h exp=%0h", k, (k < oq[3].size()) ? oq[3][k] : 8'hxx, pa[k]);
            end
            total++;
            if (k >= oq[0].size() || oq[0][k] !== pb[k] || ocyc[0][k] != start + 2 + k) begin
                bad++; $display("FAIL xbar_out0_byte%0d got=%0h exp=%0h", k, (k < oq[0].size()) ? oq[0][k] : 8'hxx, pb[k]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [7:0] fresh [3] = '{8'h82, 8'h01, 8'h02};
        int guard = 0;
        clear_logs(); out_ready = '1;
        iq[1].push_back(8'h45);
        for (int k = 1; k < 6; k++) iq[1].push_back(8'(k));
        apply_inputs();
        while (oq[1].size() < 2 && guard < 20) begin
            step();
            guard++;
        end
        total++; if (oq[1].size() != 2) begin bad++; $display("FAIL midrst_progress got=%0d exp=2", oq[1].size()); end
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL midrst_out_valid got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL midrst_in_ready got=%0h exp=0", in_ready); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL midrst_out_data got=%0h exp=0", out_data); end
        clear_logs();
        in_valid = '0; in_data = '0;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) iq[1].push_back(fresh[k]);
        apply_inputs();
        run(8);
        total++; if (oq[2].size() != 3) begin bad++; $display("FAIL midrst_fresh_len got=%0d exp=3", oq[2].size()); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (k >= oq[2].size() || oq[2][k] !== fresh[k]) begin
                bad++; $display("FAIL midrst_fresh_byte%0d got=%0h exp=%0h", k, (k < oq[2].size()) ? oq[2][k] : 8'hxx, fresh[k]);
            end
        end
        total++; if (oq[1].size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d exp=0", oq[1].size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_concurrency();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/dut_router.md
DUT_ROUTER -- requirements
Module: dut_router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of input ports and output ports.
REQ-002 SHALL have parameter DATA_W, default 8, byte width of each port.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-low; asserting it (low) clears all state immediately.
REQ-005 SHALL have port in_data, input, NUM_PORTS x DATA_W, one byte per input port.
REQ-006 SHALL have port in_valid, input, NUM_PORTS, asserted when in_data[i] holds a valid byte.
REQ-007 SHALL have port in_ready, output, NUM_PORTS, asserted when dut_router accepts in_data[i] this cycle.
REQ-008 SHALL have port out_data, output, NUM_PORTS x DATA_W, one byte per output port.
REQ-009 SHALL have port out_valid, output, NUM_PORTS, asserted when out_data[o] holds a valid byte.
REQ-010 SHALL have port out_ready, input, NUM_PORTS, asserted when the sink of output o takes the byte.

Function
REQ-011 A beat SHALL transfer on an input when in_valid[i] and in_ready[i] are both high, and on an output when out_valid[o] and out_ready[o] are both high.
REQ-012 A packet SHALL be a header byte followed by N payload bytes: header[7:6] is the destination port, header[5:0] is N (0..63); N=0 is a header-only packet.
REQ-013 Each output SHALL be IDLE or LOCKED to one input; in IDLE it round-robin arbitrates among inputs whose in_valid is high and whose current header byte addresses that output.
REQ-014 Round-robin SHALL use a per-output pointer, initialized to input 0, with priority order pointer, pointer+1, ... modulo NUM_PORTS; after a grant to input g, the pointer SHALL become g+1 mod NUM_PORTS.
REQ-015 A grant SHALL be registered: the output enters LOCKED, and in_ready of the winner may rise, on the cycle after the header is seen.
REQ-016 While output o is LOCKED to input i, in_ready[i] SHALL equal (!out_valid[o] | out_ready[o]); in_ready SHALL be low for every ungranted input.
REQ-017 An input with in_valid high and no grant SHALL hold its byte stable; dut_router SHALL never drop or reorder bytes.
REQ-018 Each output SHALL have one output register: an accepted input beat appears on out_data/out_valid the next cycle, giving 1-cycle latency.
REQ-019 out_valid[o] SHALL clear after an out_ready transfer when no new beat is loaded that cycle; a byte SHALL remain stable while out_valid is high and out_ready is low.
REQ-020 Each lock SHALL count accepted beats and release to IDLE after beat 1+N is accepted; re-arbitration SHALL start the following cycle, with no overlap between packets on one output.
REQ-021 Packets to different outputs SHALL proceed concurrently, giving full crossbar throughput of 1 byte per port per cycle.

Reset
REQ-022 While reset is low: in_ready, out_valid and out_data SHALL be 0, all outputs SHALL be IDLE, beat counters SHALL be 0, and all RR pointers SHALL be 0.
REQ-023 Reset asserted mid-packet SHALL discard the partial packet; after release, inputs restart with a header.

Structure
REQ-024 Package dut_pkg SHALL hold NUM_PORTS, DATA_W, the header field positions/typedef (dest, len), and the output state enum {IDLE, LOCKED}.
REQ-025 One sub-module, rr_arbiter (NUM_PORTS request bits, pointer, one-hot grant), SHALL be instantiated once per output; the crossbar mux and counters SHALL sit in dut_router.

Verification
REQ-026 Reset check: hold reset low for 2 ns with random inputs -> all out_valid and in_ready are 0, and the first post-reset header 0x41 on in0 is delivered to out1.
REQ-027 Single packet: in2 sends header 0xC3 plus bytes AA,BB,CC with out_ready=1 -> out3 emits C3,AA,BB,CC in consecutive cycles, with the first byte 2 cycles after the header first appears.
REQ-028 Contention: in0, in1 and in3 each send header 0x80 (dest 2, N=0) at the same time, repeated -> out2 grants in0, then in1, then in3, then in0.
REQ-029 Backpressure: out_ready[0] toggles 1,0,0,1 during a 5-byte packet to out0 -> no loss or duplication, and out_data holds while out_ready is low.
REQ-030 Concurrency: in0 sends to out3 and in3 sends to out0, each with N=10 -> both complete in 12 cycles with no stalls.
REQ-031 Mid-packet reset: assert reset after the 2nd of 6 bytes -> outputs go to 0 immediately, and a fresh packet afterwards routes correctly.
